// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// FSM state encoding and default operand width.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// One-bit full adder reused every cycle by the
// serial adder datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder, LSB first, WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed overflow output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             s_bit;
  logic             c_bit;

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state != IDLE);

  fa_bit u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (s_bit),
    .cout (c_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: IDLE -> RUN for WIDTH cycles -> DONE -> IDLE
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one sum bit per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sum   <= {s_bit, sum[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= last ? '0 : cnt + CW'(1);
        end
        DONE: begin
          cout <= carry;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: carry into MSB differs from carry out
  always_ff @(posedge clk) begin
    if (rst)
      ovf <= 1'b0;
    else if (state == RUN && last)
      ovf <= carry ^ c_bit;
  end
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have ports a and b, input, WIDTH each, operands captured on the accepted start.
REQ-006 SHALL have port cin, input, 1, carry-in captured on the accepted start.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress (RUN or DONE).
REQ-008 SHALL have port done, output, 1, a single-cycle pulse when the result is valid.
REQ-009 SHALL have port sum, output, WIDTH, registered result.
REQ-010 SHALL have port cout, output, 1, registered carry-out.
REQ-011 SHALL have port ovf, output, 1, signed overflow, present only under SERIAL_ADD_OVF_EN.

Function
REQ-012 SHALL use one bit-serial full adder, reused over WIDTH cycles, LSB first, with a carry flip-flop between cycles.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1, SHALL load a, b and cin into shift/carry registers, clear the bit counter, and enter RUN.
REQ-015 In RUN, each cycle SHALL add the current LSBs plus the carry register, shift the sum bit into sum from the MSB side, update the carry, and increment the counter.
REQ-016 SHALL leave RUN for DONE after exactly WIDTH RUN cycles (counter wraps at WIDTH-1).
REQ-017 In DONE, SHALL assert done for one cycle, drive cout from the final carry, and return to IDLE.
REQ-018 Latency SHALL be fixed: start accepted at edge t gives done=1 in the cycle after edge t+WIDTH+1.
REQ-019 SHALL ignore start while busy=1, including in the DONE cycle; a held start is accepted in the following IDLE cycle.
REQ-020 sum and cout SHALL hold their last values from DONE until the next accepted start.
REQ-021 SHALL ignore a/b/cin changes after capture.

Reset
REQ-022 When rst=1 at a clock edge, SHALL enter IDLE and clear busy, done, sum, cout, ovf, the counter and the carry register to 0, including mid-RUN.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SERIAL_ADD_OVF_EN defined, SHALL register ovf = carry into MSB XOR carry out of MSB at the final RUN cycle, valid with done and held like sum.
REQ-025 Without SERIAL_ADD_OVF_EN, SHALL omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-026 Package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-027 The one-bit adder SHALL be a sub-module named fa_bit (a, b, cin -> sum, cout), instantiated once.

Verification
REQ-028 WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse -> done after 10 cycles, sum=0x10, cout=0, busy high for 9 cycles.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1; a=0x05, b=0x03 -> ovf=0.
REQ-031 Start pulse and new operands during RUN -> ignored; the original result is delivered unchanged.
REQ-032 rst asserted at the fourth RUN cycle -> next cycle IDLE with all outputs 0; a fresh start then completes correctly.
REQ-033 start held high continuously -> back-to-back operations, one done every WIDTH+2 cycles, each result correct.
